leds_frame_scheduler: RTL and testbench

//   Sequences one refresh of the racer LED strip. On an update request it snapshots the four

---
 rtl/leds_frame_scheduler.sv | 167 ++++++++++++++++
 tb/tb_leds_frame_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leds_frame_scheduler.sv
// Frame sequencer for the racer LED strip: snapshots player positions, streams one GRB word
// per LED over valid/ready, then holds the line idle for the strip latch gap.
module leds_frame_scheduler #(
    parameter int MAX_POS       = 109,
    parameter int POS_W         = 7,
    parameter int LATCH_CLK_CNT = 4000
) (
    input  logic             clk,
    input  logic             force_reset,
    input  logic             update_frame,
    input  logic [POS_W-1:0] blue_pos,
    input  logic [POS_W-1:0] red_pos,
    input  logic [POS_W-1:0] green_pos,
    input  logic [POS_W-1:0] yellow_pos,
    output logic [23:0]      pix_data,
    output logic [POS_W-1:0] pix_index,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int                CNT_W    = (LATCH_CLK_CNT > 1) ? $clog2(LATCH_CLK_CNT) : 1;
    localparam logic [POS_W-1:0]  LAST_IDX = POS_W'(MAX_POS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LATCH_CLK_CNT - 1);

    localparam logic [23:0] GRB_BLUE   = 24'h0000FF;
    localparam logic [23:0] GRB_RED    = 24'h00FF00;
    localparam logic [23:0] GRB_GREEN  = 24'hFF0000;
    localparam logic [23:0] GRB_YELLOW = 24'hFFFF00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_LATCH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [POS_W-1:0]   r_snap_blue;
    logic [POS_W-1:0]   r_snap_red;
    logic [POS_W-1:0]   r_snap_green;
    logic [POS_W-1:0]   r_snap_yellow;
    logic [POS_W-1:0]   r_index;
    logic               r_valid;
    logic               r_pending;
    logic [CNT_W-1:0]   r_latch_cnt;

    logic               w_xfer;
    logic               w_last_xfer;
    logic               w_latch_last;
    logic               w_start;
    logic [23:0]        w_colour;

    // Widened compare so MAX_POS == 2**POS_W still works.
    function automatic logic on_pixel(input logic [POS_W-1:0] pos, input logic [POS_W-1:0] idx);
        return (pos == idx) && ({1'b0, pos} < (POS_W + 1)'(MAX_POS));
    endfunction

    assign w_xfer       = r_valid & pix_ready;
    assign w_last_xfer  = w_xfer && (r_index == LAST_IDX);
    assign w_latch_last = (r_state == S_LATCH) && (r_latch_cnt == LAST_CNT);

    // NOTE: the state register only holds state; everything it feeds is decided below.
    always_ff @(posedge clk or posedge force_reset) begin
        if (force_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: defaults first, so no path through the case leaves an output unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (update_frame) begin
                    w_state_nxt = S_STREAM;
                    w_start     = 1'b1;
                end
            end
            S_STREAM: begin
                if (w_last_xfer) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                if (w_latch_last) begin
                    if (r_pending || update_frame) begin
                        w_state_nxt = S_STREAM;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge force_reset) begin
        if (force_reset) begin
            r_snap_blue   <= '0;
            r_snap_red    <= '0;
            r_snap_green  <= '0;
            r_snap_yellow <= '0;
            r_index       <= '0;
            r_valid       <= 1'b0;
            r_pending     <= 1'b0;
            r_latch_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_snap_blue   <= blue_pos;
                r_snap_red    <= red_pos;
                r_snap_green  <= green_pos;
                r_snap_yellow <= yellow_pos;
                r_index       <= '0;
                r_valid       <= 1'b1;
            end else if (w_xfer) begin
                if (r_index == LAST_IDX) begin
                    r_valid <= 1'b0;
                end else begin
                    r_index <= r_index + POS_W'(1);
                end
            end

            if (r_state == S_LATCH && !w_latch_last) begin
                r_latch_cnt <= r_latch_cnt + CNT_W'(1);
            end else begin
                r_latch_cnt <= '0;
            end

            // A restart consumes every outstanding request, including one arriving this cycle.
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (update_frame && r_state != S_IDLE) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_colour = 24'h000000;
        if (on_pixel(r_snap_blue, r_index)) begin
            w_colour = GRB_BLUE;
        end else if (on_pixel(r_snap_red, r_index)) begin
            w_colour = GRB_RED;
        end else if (on_pixel(r_snap_green, r_index)) begin
            w_colour = GRB_GREEN;
        end else if (on_pixel(r_snap_yellow, r_index)) begin
            w_colour = GRB_YELLOW;
        end
    end

    assign pix_data   = r_valid ? w_colour : 24'h000000;
    assign pix_index  = r_index;
    assign pix_valid  = r_valid;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = w_latch_last;

endmodule

// File: tb/tb_leds_frame_scheduler.sv
// Directed bench for leds_frame_scheduler: colour map, priority, stalls, request coalescing,
// snapshot isolation and asynchronous reset mid-frame.
module tb_leds_frame_scheduler;

    localparam int MAX_POS = 109;
    localparam int POS_W   = 7;
    localparam int LATCH   = 4000;

    logic             clk = 1'b0;
    logic             force_reset;
    logic             update_frame;
    logic [POS_W-1:0] blue_pos;
    logic [POS_W-1:0] red_pos;
    logic [POS_W-1:0] green_pos;
    logic [POS_W-1:0] yellow_pos;
    logic [23:0]      pix_data;
    logic [POS_W-1:0] pix_index;
    logic             pix_valid;
    logic             pix_ready;
    logic             busy;
    logic             frame_done;

    int errors = 0;
    int checks = 0;

    logic [23:0]      got_data [MAX_POS];
    int               got_count;
    int               order_err;
    int               stall_err;
    int               gap_err;
    int               cycles;
    int               latch_n;
    int               blue_cnt;
    logic [POS_W-1:0] new_b, new_r, new_g, new_y;

    always #5 clk = ~clk;

    leds_frame_scheduler #(
        .MAX_POS       (MAX_POS),
        .POS_W         (POS_W),
        .LATCH_CLK_CNT (LATCH)
    ) dut (
        .clk          (clk),
        .force_reset  (force_reset),
        .update_frame (update_frame),
        .blue_pos     (blue_pos),
        .red_pos      (red_pos),
        .green_pos    (green_pos),
        .yellow_pos   (yellow_pos),
        .pix_data     (pix_data),
        .pix_index    (pix_index),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int b, input int r, input int g, input int y);
        blue_pos   = POS_W'(b);
        red_pos    = POS_W'(r);
        green_pos  = POS_W'(g);
        yellow_pos = POS_W'(y);
    endtask

    task automatic start_frame(input string tag);
        update_frame = 1'b1;
        tick();
        update_frame = 1'b0;
        check({tag, "_start_valid"}, 32'(pix_valid), 32'd1);
        check({tag, "_start_idx"},   32'(pix_index), 32'd0);
        check({tag, "_start_busy"},  32'(busy),      32'd1);
    endtask

    // Accepts words until a full frame is captured; optional request pulses and position change.
    task automatic stream_frame(input string tag, input int stall_pct,
                                input int pa, input int pb, input int pc, input int chg_at);
        logic [23:0]      held_d;
        logic [POS_W-1:0] held_i;
        bit               stalled;
        got_count = 0;
        order_err = 0;
        stall_err = 0;
        gap_err   = 0;
        cycles    = 0;
        stalled   = 1'b0;
        held_d    = '0;
        held_i    = '0;
        while (got_count < MAX_POS && cycles < 2000) begin
            pix_ready    = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
            update_frame = (cycles == pa || cycles == pb || cycles == pc);
            if (cycles == chg_at) begin
                blue_pos   = new_b;
                red_pos    = new_r;
                green_pos  = new_g;
                yellow_pos = new_y;
            end
            if (!pix_valid) begin
                gap_err++;
            end else begin
                if (stalled && (pix_data !== held_d || pix_index !== held_i)) stall_err++;
                if (pix_ready) begin
                    if (pix_index !== POS_W'(got_count)) order_err++;
                    got_data[got_count] = pix_data;
                    got_count++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = pix_data;
                    held_i  = pix_index;
                end
            end
            tick();
            cycles++;
        end
        pix_ready    = 1'b1;
        update_frame = 1'b0;
        check({tag, "_count"},     32'(got_count), 32'(MAX_POS));
        check({tag, "_order"},     32'(order_err), 32'd0);
        check({tag, "_stall_hold"}, 32'(stall_err), 32'd0);
        check({tag, "_no_gap"},    32'(gap_err),   32'd0);
        check({tag, "_end_valid"}, 32'(pix_valid), 32'd0);
    endtask

    // Runs out the latch gap; optionally raises update_frame on the frame_done cycle.
    task automatic finish_latch(input string tag, input bit req_on_done);
        int bad;
        bad     = 0;
        latch_n = 0;
        while (!frame_done && latch_n < LATCH + 100) begin
            if (pix_valid !== 1'b0 || busy !== 1'b1) bad++;
            tick();
            latch_n++;
        end
        check({tag, "_latch_len"},  32'(latch_n),    32'(LATCH - 1));
        check({tag, "_latch_idle"}, 32'(bad),        32'd0);
        check({tag, "_done_valid"}, 32'(pix_valid),  32'd0);
        update_frame = req_on_done;
        tick();
        update_frame = 1'b0;
        check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
    endtask

    function automatic logic [23:0] t1_expect(input int i);
        case (i)
            0:       return 24'h0000FF;
            5:       return 24'h00FF00;
            10:      return 24'hFF0000;
            108:     return 24'hFFFF00;
            default: return 24'h000000;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        force_reset  = 1'b1;
        update_frame = 1'b0;
        pix_ready    = 1'b1;
        new_b = '0; new_r = '0; new_g = '0; new_y = '0;
        set_pos(0, 0, 0, 0);
        repeat (2) tick();
        check("rst_valid", 32'(pix_valid),  32'd0);
        check("rst_data",  32'(pix_data),   32'd0);
        check("rst_index", 32'(pix_index),  32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        force_reset = 1'b0;
        repeat (3) tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Basic colour map, back-to-back words, latch gap then IDLE
        set_pos(0, 5, 10, 108);
        start_frame("t1");
        stream_frame("t1", 0, -1, -1, -1, -1);
        check("t1_cycles", 32'(cycles), 32'(MAX_POS));
        for (int i = 0; i < MAX_POS; i++) begin
            check($sformatf("t1_pix%0d", i), 32'(got_data[i]), 32'(t1_expect(i)));
        end
        check("t1_latch_busy", 32'(busy), 32'd1);
        finish_latch("t1", 1'b0);
        check("t1_idle_busy",  32'(busy),      32'd0);
        check("t1_idle_valid", 32'(pix_valid), 32'd0);

        // Priority: blue wins; out-of-range blue hands the LED to red
        set_pos(20, 20, 20, 20);
        start_frame("t2a");
        stream_frame("t2a", 0, -1, -1, -1, -1);
        check("t2a_pix20", 32'(got_data[20]), 32'h0000FF);
        check("t2a_pix19", 32'(got_data[19]), 32'h000000);
        finish_latch("t2a", 1'b0);
        set_pos(127, 20, 20, 20);
        start_frame("t2b");
        stream_frame("t2b", 0, -1, -1, -1, -1);
        check("t2b_pix20", 32'(got_data[20]), 32'h00FF00);
        blue_cnt = 0;
        for (int i = 0; i < MAX_POS; i++) if (got_data[i] == 24'h0000FF) blue_cnt++;
        check("t2b_no_blue", 32'(blue_cnt), 32'd0);
        finish_latch("t2b", 1'b0);

        // Random backpressure
        set_pos(0, 5, 10, 108);
        start_frame("t3");
        stream_frame("t3", 50, -1, -1, -1, -1);
        check("t3_pix5",   32'(got_data[5]),   32'h00FF00);
        check("t3_pix108", 32'(got_data[108]), 32'hFFFF00);
        finish_latch("t3", 1'b0);

        // Coalesced requests: three in STREAM plus one on frame_done -> one follow-up frame
        start_frame("t4");
        stream_frame("t4", 0, 10, 40, 80, -1);
        finish_latch("t4", 1'b1);
        check("t4_follow_valid", 32'(pix_valid), 32'd1);
        check("t4_follow_idx",   32'(pix_index), 32'd0);
        check("t4_follow_busy",  32'(busy),      32'd1);
        stream_frame("t4f", 0, -1, -1, -1, -1);
        finish_latch("t4f", 1'b0);
        check("t4_idle_busy", 32'(busy), 32'd0);
        repeat (20) tick();
        check("t4_stay_idle",  32'(busy),      32'd0);
        check("t4_stay_valid", 32'(pix_valid), 32'd0);

        // Snapshot isolation against live position changes
        set_pos(30, 40, 50, 60);
        new_b = 7'd70; new_r = 7'd80; new_g = 7'd90; new_y = 7'd100;
        start_frame("t5a");
        stream_frame("t5a", 0, -1, -1, -1, 20);
        check("t5a_pix30",  32'(got_data[30]),  32'h0000FF);
        check("t5a_pix40",  32'(got_data[40]),  32'h00FF00);
        check("t5a_pix50",  32'(got_data[50]),  32'hFF0000);
        check("t5a_pix60",  32'(got_data[60]),  32'hFFFF00);
        check("t5a_pix70",  32'(got_data[70]),  32'h000000);
        check("t5a_pix100", 32'(got_data[100]), 32'h000000);
        finish_latch("t5a", 1'b0);
        start_frame("t5b");
        stream_frame("t5b", 0, -1, -1, -1, -1);
        check("t5b_pix70",  32'(got_data[70]),  32'h0000FF);
        check("t5b_pix90",  32'(got_data[90]),  32'hFF0000);
        check("t5b_pix100", 32'(got_data[100]), 32'hFFFF00);
        check("t5b_pix30",  32'(got_data[30]),  32'h000000);
        finish_latch("t5b", 1'b0);

        // Asynchronous reset at index 50
        set_pos(0, 5, 10, 108);
        start_frame("t6");
        repeat (50) tick();
        check("t6_idx50", 32'(pix_index), 32'd50);
        force_reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(pix_valid), 32'd0);
        check("t6_rst_busy",  32'(busy),      32'd0);
        check("t6_rst_index", 32'(pix_index), 32'd0);
        check("t6_rst_data",  32'(pix_data),  32'd0);
        repeat (2) tick();
        force_reset = 1'b0;
        repeat (5) tick();
        check("t6_post_busy",  32'(busy),      32'd0);
        check("t6_post_valid", 32'(pix_valid), 32'd0);
        start_frame("t6n");
        stream_frame("t6n", 0, -1, -1, -1, -1);
        check("t6n_pix0", 32'(got_data[0]), 32'h0000FF);
        finish_latch("t6n", 1'b0);
        check("t6n_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
